data_memory_banked: RTL and testbench
=====================================

# data_memory_banked

Parametrised single-port data memory for the 16-bit datapath, serving the memory stage with byte (lbu/sb) and halfword (lw/sw) accesses through a req/ready handshake. Storage is DEPTH halfwords split into two byte lanes, addressed by byte, little-endian. After reset it self-initialises to zero plus a fixed preload table, and it supports misaligned halfword accesses as a two-cycle split transaction.

## Interface
- ADDR_WIDTH, 16: byte-address width.
- DEPTH, 256: number of 16-bit words; power of 2, at least 8. The word index is address[log2(DEPTH):1]; higher address bits are ignored (aliased).
- PRELOAD, 1: 1 = load the preload table during init; 0 = clear to zero only.
- ALLOW_MISALIGNED, 1: 1 = split misaligned halfword accesses; 0 = reject them with misalign_err.
- clk, in, 1: the single clock; all state updates on its rising edge.
- reset, in, 1: asynchronous, active-high.
- req, in, 1: access request.
- memWrite, in, 1: 1 = store, 0 = load. Sampled with req.
- byte_en, in, 1: 1 = byte access, 0 = halfword access.
- address, in, ADDR_WIDTH: byte address.
- writeData, in, 16: store data. Byte stores use [7:0].
- ready, out, 1: the block can accept a request this cycle.
- readValid, out, 1: one-cycle pulse; readData is valid while it is high.
- readData, out, 16: load result. Byte loads are zero-extended.
- misalign_err, out, 1: one-cycle pulse when a misaligned request is rejected.

## Operation
- A request is accepted on a rising edge where req && ready.
- States:
  - INIT: entered from reset.
  - IDLE: accepts requests.
  - SPLIT: second half of a misaligned halfword.
- INIT:
  - A counter walks word 0 to DEPTH-1, writing one word per cycle. The counter is wrapped, so init takes exactly DEPTH cycles.
  - Each word is written with 0, except when PRELOAD=1, where words 0..4 get 0x3856, 0x0000, 0x4312, 0xBEDE, 0xADEF.
  - After the write of word DEPTH-1 the FSM goes to IDLE.
- Byte access, any address: one lane of one word, selected by address[0].
- Aligned halfword (address[0]=0):
  - Load: lane0 goes to readData[7:0], lane1 to readData[15:8].
  - Store: writes both lanes.
- Misaligned halfword with ALLOW_MISALIGNED=1:
  - The accept cycle handles the low byte, lane1 of word W.
  - The next cycle (SPLIT) handles the high byte, lane0 of word W+1 mod DEPTH.
  - The latched address and writeData are used in SPLIT; live inputs are ignored.
  - The word wraps from DEPTH-1 to 0.
- Misaligned halfword with ALLOW_MISALIGNED=0:
  - No memory change and no readValid.
  - misalign_err pulses in the cycle after accept.
  - The FSM stays in IDLE.
- Bytes not addressed by a store are never modified.
- ready = (state == IDLE). ready is low in INIT and SPLIT.
- Reset at any time, including mid-SPLIT or mid-INIT:
  - The pending access is aborted.
  - All outputs go to 0 immediately.
  - The FSM returns to INIT with the counter at 0, and memory is re-initialised.

## Timing
- Reset values: ready=0, readValid=0, readData=0x0000, misalign_err=0, state=INIT, counter=0.
- First ready=1 is DEPTH cycles after reset deasserts.
- Loads:
  - Aligned halfword or byte load accepted at edge N: readValid=1 and readData valid during cycle N+1 (after edge N). Latency is 1.
  - Misaligned load accepted at edge N: SPLIT during cycle N+1, readValid during cycle N+2. ready returns at N+2, so back-to-back requests are allowed.
  - readData holds its last value when readValid=0.
- Stores:
  - An aligned store is visible to a load accepted at edge N+1.
  - A misaligned store completes at edge N+1, and is visible to a load accepted at N+2.
  - Stores never raise readValid.
- Throughput:
  - Aligned accesses: 1 per cycle.
  - Misaligned accesses: 1 per 2 cycles.

## Test plan
- Reset then idle:
  - ready stays 0 for exactly DEPTH cycles, then rises.
  - Halfword load at 0x0004 -> readData=0x4312 one cycle after accept.
  - Byte load at 0x0007 -> 0x00BE.
- Store/load: sw 0xA55A at 0x0010, then lbu 0x0011 -> 0x00A5.
  - sb 0x77 at 0x0010, then lw 0x0010 -> 0xA577.
  - Confirm the neighbouring byte is unchanged.
- Misaligned, ALLOW_MISALIGNED=1:
  - sw 0x1234 at 0x0021 -> word 0x10 lane1=0x34, word 0x11 lane0=0x12.
  - lw 0x0021 -> 0x1234 with readValid two cycles after accept, and ready low for one cycle.
- Wrap: with DEPTH=256, sw 0xCAFE at 0x01FF -> lbu 0x01FF=0xFE, lbu 0x0000=0xCA.
  - Also check aliasing: lbu 0x0200 = lbu 0x0000.
- ALLOW_MISALIGNED=0: lw 0x0003 -> misalign_err pulse one cycle after accept, no readValid, memory unchanged.
- Reset mid-SPLIT of a misaligned store:
  - Outputs go to 0 immediately.
  - After DEPTH cycles, lw 0x0000 returns 0x3856 (PRELOAD=1) or 0x0000 (PRELOAD=0).
  - The target bytes read 0.

Source files
------------

// File: rtl/data_memory_banked_if.sv
// data_memory_banked_if
//   Request/response bundle between the memory stage and data_memory_banked.
//   master : drives req/memWrite/byte_en/address/writeData, observes the rest.
//   slave  : the memory; drives ready/readValid/readData/misalign_err.
interface data_memory_banked_if #(
  parameter int ADDR_WIDTH = 16
);
  logic                  req;
  logic                  memWrite;
  logic                  byte_en;
  logic [ADDR_WIDTH-1:0] address;
  logic [15:0]           writeData;
  logic                  ready;
  logic                  readValid;
  logic [15:0]           readData;
  logic                  misalign_err;

  modport master (
    output req, memWrite, byte_en, address, writeData,
    input  ready, readValid, readData, misalign_err
  );

  modport slave (
    input  req, memWrite, byte_en, address, writeData,
    output ready, readValid, readData, misalign_err
  );
endinterface

// File: rtl/data_memory_banked.sv
// data_memory_banked
//   Single-port, byte-addressed, little-endian data memory of DEPTH halfwords
//   held as two byte lanes. Self-initialises after reset (zero plus optional
//   preload table), serves byte and halfword loads/stores, and splits a
//   misaligned halfword into two cycles (or rejects it).
// Ports
//   clk   : clock, all state on rising edge
//   reset : asynchronous, active-high
//   bus   : slave side of data_memory_banked_if (req/ready handshake,
//           load/store controls, readValid/readData, misalign_err)
module data_memory_banked #(
  parameter int ADDR_WIDTH       = 16,
  parameter int DEPTH            = 256,
  parameter int PRELOAD          = 1,
  parameter int ALLOW_MISALIGNED = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  data_memory_banked_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] LAST_WORD = AW'(DEPTH - 1);
  localparam logic [AW-1:0] ONE_WORD  = AW'(1);

  typedef enum logic [1:0] {
    S_INIT  = 2'd0,
    S_IDLE  = 2'd1,
    S_SPLIT = 2'd2
  } state_t;

  // Init value of a word: preload table for words 0..4 when enabled.
  function automatic logic [15:0] init_word(input logic [AW-1:0] idx);
    logic [15:0] val;
    if (PRELOAD != 0) begin
      case (idx)
        AW'(0):  val = 16'h3856;
        AW'(1):  val = 16'h0000;
        AW'(2):  val = 16'h4312;
        AW'(3):  val = 16'hBEDE;
        AW'(4):  val = 16'hADEF;
        default: val = 16'h0000;
      endcase
    end else begin
      val = 16'h0000;
    end
    return val;
  endfunction

  state_t          state_q, state_d;
  logic [AW-1:0]   cnt_q, cnt_d;
  logic            rvalid_q, rvalid_d;
  logic [15:0]     rdata_q, rdata_d;
  logic            err_q, err_d;
  logic [AW-1:0]   split_word_q, split_word_d;
  logic [7:0]      split_byte_q, split_byte_d;
  logic            split_wr_q, split_wr_d;
  logic [7:0]      lo_byte_q, lo_byte_d;

  logic [7:0]      mem_lane0_q [DEPTH];
  logic [7:0]      mem_lane1_q [DEPTH];

  logic            we0_s, we1_s;
  logic [AW-1:0]   wa0_s, wa1_s;
  logic [7:0]      wd0_s, wd1_s;
  logic [AW-1:0]   word_s;
  logic            accept_s;
  logic [15:0]     init_val_s;
  logic            unused_addr_s;

  // Upper address bits alias; word index skips the lane-select bit.
  assign word_s        = bus.address[AW:1];
  assign unused_addr_s = ^{bus.address[ADDR_WIDTH-1:AW+1]};
  assign accept_s      = bus.req && (state_q == S_IDLE);
  assign init_val_s    = init_word(cnt_q);

  assign bus.ready        = (state_q == S_IDLE);
  assign bus.readValid    = rvalid_q;
  assign bus.readData     = rdata_q;
  assign bus.misalign_err = err_q;

  // Next-state, memory port controls and output computation.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    rvalid_d     = 1'b0;
    rdata_d      = rdata_q;
    err_d        = 1'b0;
    split_word_d = split_word_q;
    split_byte_d = split_byte_q;
    split_wr_d   = split_wr_q;
    lo_byte_d    = lo_byte_q;
    we0_s        = 1'b0;
    we1_s        = 1'b0;
    wa0_s        = word_s;
    wa1_s        = word_s;
    wd0_s        = bus.writeData[7:0];
    wd1_s        = bus.writeData[15:8];

    case (state_q)
      S_INIT: begin
        we0_s = 1'b1;
        we1_s = 1'b1;
        wa0_s = cnt_q;
        wa1_s = cnt_q;
        wd0_s = init_val_s[7:0];
        wd1_s = init_val_s[15:8];
        cnt_d = cnt_q + ONE_WORD;  // wraps to 0 after the last word
        if (cnt_q == LAST_WORD) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_INIT;
        end
      end

      S_IDLE: begin
        if (!accept_s) begin
          state_d = S_IDLE;
        end else if (bus.byte_en) begin
          // Byte store always takes its data from writeData[7:0].
          wd1_s = bus.writeData[7:0];
          if (bus.memWrite) begin
            we0_s = !bus.address[0];
            we1_s = bus.address[0];
          end else begin
            rvalid_d = 1'b1;
            rdata_d  = bus.address[0] ? {8'h00, mem_lane1_q[word_s]}
                                      : {8'h00, mem_lane0_q[word_s]};
          end
        end else if (!bus.address[0]) begin
          if (bus.memWrite) begin
            we0_s = 1'b1;
            we1_s = 1'b1;
          end else begin
            rvalid_d = 1'b1;
            rdata_d  = {mem_lane1_q[word_s], mem_lane0_q[word_s]};
          end
        end else if (ALLOW_MISALIGNED != 0) begin
          // Low byte lives in lane1 of W; the high byte is deferred to SPLIT
          // on lane0 of W+1, using the values latched here.
          split_word_d = word_s + ONE_WORD;
          split_byte_d = bus.writeData[15:8];
          split_wr_d   = bus.memWrite;
          state_d      = S_SPLIT;
          if (bus.memWrite) begin
            we1_s = 1'b1;
            wd1_s = bus.writeData[7:0];
          end else begin
            lo_byte_d = mem_lane1_q[word_s];
          end
        end else begin
          err_d = 1'b1;
        end
      end

      S_SPLIT: begin
        state_d = S_IDLE;
        wa0_s   = split_word_q;
        wd0_s   = split_byte_q;
        if (split_wr_q) begin
          we0_s = 1'b1;
        end else begin
          rvalid_d = 1'b1;
          rdata_d  = {mem_lane0_q[split_word_q], lo_byte_q};
        end
      end

      default: begin
        state_d = S_INIT;
        cnt_d   = '0;
      end
    endcase
  end

  // Control and output registers; reset aborts any access and restarts init.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_INIT;
      cnt_q        <= '0;
      rvalid_q     <= 1'b0;
      rdata_q      <= 16'h0000;
      err_q        <= 1'b0;
      split_word_q <= '0;
      split_byte_q <= 8'h00;
      split_wr_q   <= 1'b0;
      lo_byte_q    <= 8'h00;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      rvalid_q     <= rvalid_d;
      rdata_q      <= rdata_d;
      err_q        <= err_d;
      split_word_q <= split_word_d;
      split_byte_q <= split_byte_d;
      split_wr_q   <= split_wr_d;
      lo_byte_q    <= lo_byte_d;
    end
  end

  // Byte-lane storage; contents are rebuilt by INIT so no reset is needed.
  always_ff @(posedge clk) begin
    if (we0_s) begin
      mem_lane0_q[wa0_s] <= wd0_s;
    end
    if (we1_s) begin
      mem_lane1_q[wa1_s] <= wd1_s;
    end
  end

endmodule

// File: tb/tb_data_memory_banked.sv
// tb_data_memory_banked
//   Directed bench: dut_a (DEPTH=256, preload, misaligned split) and
//   dut_b (DEPTH=16, no preload, misaligned rejected).
module tb_data_memory_banked;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  data_memory_banked_if #(.ADDR_WIDTH(16)) bus_a ();
  data_memory_banked_if #(.ADDR_WIDTH(16)) bus_b ();

  data_memory_banked #(.ADDR_WIDTH(16), .DEPTH(256), .PRELOAD(1), .ALLOW_MISALIGNED(1))
    dut_a (.clk(clk), .reset(reset), .bus(bus_a));

  data_memory_banked #(.ADDR_WIDTH(16), .DEPTH(16), .PRELOAD(0), .ALLOW_MISALIGNED(0))
    dut_b (.clk(clk), .reset(reset), .bus(bus_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic        be;
    logic [15:0] addr;
    logic [15:0] wd;
    logic        exp_rv;
    logic [15:0] exp_rd;
  } vec_t;

  localparam int NV = 12;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input bit sel, input logic r, input logic w, input logic b,
                       input logic [15:0] a, input logic [15:0] d);
    if (sel == 1'b0) begin
      bus_a.req = r; bus_a.memWrite = w; bus_a.byte_en = b;
      bus_a.address = a; bus_a.writeData = d;
    end else begin
      bus_b.req = r; bus_b.memWrite = w; bus_b.byte_en = b;
      bus_b.address = a; bus_b.writeData = d;
    end
  endtask

  task automatic sample(input bit sel, output logic rdy, output logic rv,
                        output logic err, output logic [15:0] rd);
    if (sel == 1'b0) begin
      rdy = bus_a.ready; rv = bus_a.readValid; err = bus_a.misalign_err; rd = bus_a.readData;
    end else begin
      rdy = bus_b.ready; rv = bus_b.readValid; err = bus_b.misalign_err; rd = bus_b.readData;
    end
  endtask

  task automatic wait_ready(input bit sel);
    logic rdy, rv, err;
    logic [15:0] rd;
    int k;
    k = 0;
    sample(sel, rdy, rv, err, rd);
    while (!rdy && k < 1000) begin
      @(posedge clk); #1;
      k++;
      sample(sel, rdy, rv, err, rd);
    end
    if (!rdy) begin
      n_checks++;
      n_fail++;
      $display("FAIL ready_timeout: got ready=0 after %0d cycles, required ready=1", k);
    end
  endtask

  // Issue one request; returns outputs sampled 1 time unit after the accept edge.
  task automatic op(input bit sel, input logic w, input logic b, input logic [15:0] a,
                    input logic [15:0] d, output logic rdy, output logic rv,
                    output logic err, output logic [15:0] rd);
    wait_ready(sel);
    drive(sel, 1'b1, w, b, a, d);
    @(posedge clk); #1;
    drive(sel, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    sample(sel, rdy, rv, err, rd);
  endtask

  // Load and compare the data word.
  task automatic load_chk(input bit sel, input string name, input logic b,
                          input logic [15:0] a, input logic [15:0] exp);
    logic rdy, rv, err;
    logic [15:0] rd;
    op(sel, 1'b0, b, a, 16'h0000, rdy, rv, err, rd);
    chk({name, "_valid"}, 16'(rv), 16'h0001);
    chk(name, rd, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic rdy, rv, err;
    logic [15:0] rd;
    logic early;

    n_checks = 0;
    n_fail   = 0;

    vecs[0]  = '{1'b0, 1'b0, 16'h0004, 16'h0000, 1'b1, 16'h4312};
    vecs[1]  = '{1'b0, 1'b1, 16'h0007, 16'h0000, 1'b1, 16'h00BE};
    vecs[2]  = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'h3856};
    vecs[3]  = '{1'b0, 1'b1, 16'h0008, 16'h0000, 1'b1, 16'h00EF};
    vecs[4]  = '{1'b1, 1'b0, 16'h0010, 16'hA55A, 1'b0, 16'h0000};
    vecs[5]  = '{1'b0, 1'b1, 16'h0011, 16'h0000, 1'b1, 16'h00A5};
    vecs[6]  = '{1'b1, 1'b1, 16'h0010, 16'hFF77, 1'b0, 16'h0000};
    vecs[7]  = '{1'b0, 1'b0, 16'h0010, 16'h0000, 1'b1, 16'hA577};
    vecs[8]  = '{1'b0, 1'b1, 16'h0011, 16'h0000, 1'b1, 16'h00A5};
    vecs[9]  = '{1'b0, 1'b0, 16'h0002, 16'h0000, 1'b1, 16'h0000};
    vecs[10] = '{1'b1, 1'b0, 16'h0030, 16'hCAFE, 1'b0, 16'h0000};
    vecs[11] = '{1'b0, 1'b0, 16'h0230, 16'h0000, 1'b1, 16'hCAFE};

    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    #2;
    sample(1'b0, rdy, rv, err, rd);
    chk("rst_ready", 16'(rdy), 16'h0000);
    chk("rst_valid", 16'(rv), 16'h0000);
    chk("rst_err", 16'(err), 16'h0000);
    chk("rst_data", rd, 16'h0000);

    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    // Init length: dut_b ready after 16 edges, dut_a after 256.
    early = 1'b0;
    for (int n = 1; n <= 256; n++) begin
      @(posedge clk); #1;
      if (n < 256 && bus_a.ready) early = 1'b1;
      if (n == 15)  chk("b_init_ready_15", 16'(bus_b.ready), 16'h0000);
      if (n == 16)  chk("b_init_ready_16", 16'(bus_b.ready), 16'h0001);
      if (n == 256) chk("a_init_ready_256", 16'(bus_a.ready), 16'h0001);
    end
    chk("a_init_ready_early", 16'(early), 16'h0000);

    // Aligned and byte accesses from the table.
    for (int i = 0; i < NV; i++) begin
      op(1'b0, vecs[i].wr, vecs[i].be, vecs[i].addr, vecs[i].wd, rdy, rv, err, rd);
      chk($sformatf("vec%0d_valid", i), 16'(rv), 16'(vecs[i].exp_rv));
      if (vecs[i].exp_rv) begin
        chk($sformatf("vec%0d_data", i), rd, vecs[i].exp_rd);
      end else begin
        chk($sformatf("vec%0d_err", i), 16'(err), 16'h0000);
      end
    end

    // Misaligned store at 0x0021.
    op(1'b0, 1'b1, 1'b0, 16'h0021, 16'h1234, rdy, rv, err, rd);
    chk("mis_st_ready_low", 16'(rdy), 16'h0000);
    chk("mis_st_no_valid", 16'(rv), 16'h0000);
    chk("hold_after_store", rd, 16'hCAFE);
    @(posedge clk); #1;
    chk("mis_st_ready_back", 16'(bus_a.ready), 16'h0001);
    chk("mis_st_split_no_valid", 16'(bus_a.readValid), 16'h0000);
    load_chk(1'b0, "mis_st_lo", 1'b1, 16'h0021, 16'h0034);
    load_chk(1'b0, "mis_st_hi", 1'b1, 16'h0022, 16'h0012);

    // Misaligned load with junk on live inputs during SPLIT.
    op(1'b0, 1'b0, 1'b0, 16'h0021, 16'h0000, rdy, rv, err, rd);
    chk("mis_ld_ready_low", 16'(rdy), 16'h0000);
    chk("mis_ld_split_no_valid", 16'(rv), 16'h0000);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 16'h0040, 16'hFFFF);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    sample(1'b0, rdy, rv, err, rd);
    chk("mis_ld_valid", 16'(rv), 16'h0001);
    chk("mis_ld_data", rd, 16'h1234);
    chk("mis_ld_ready_back", 16'(rdy), 16'h0001);
    load_chk(1'b0, "split_junk_ignored", 1'b0, 16'h0040, 16'h0000);
    load_chk(1'b0, "back_to_back", 1'b0, 16'h0010, 16'hA577);

    // Word wrap and address aliasing.
    op(1'b0, 1'b1, 1'b0, 16'h01FF, 16'hCAFE, rdy, rv, err, rd);
    load_chk(1'b0, "wrap_lo", 1'b1, 16'h01FF, 16'h00FE);
    load_chk(1'b0, "wrap_hi", 1'b1, 16'h0000, 16'h00CA);
    load_chk(1'b0, "alias_0200", 1'b1, 16'h0200, 16'h00CA);
    load_chk(1'b0, "wrap_neighbour", 1'b1, 16'h0001, 16'h0038);

    // dut_b: misaligned accesses rejected.
    op(1'b1, 1'b1, 1'b0, 16'h0002, 16'h1111, rdy, rv, err, rd);
    op(1'b1, 1'b0, 1'b0, 16'h0003, 16'h0000, rdy, rv, err, rd);
    chk("nm_ld_err", 16'(err), 16'h0001);
    chk("nm_ld_no_valid", 16'(rv), 16'h0000);
    chk("nm_ld_ready", 16'(rdy), 16'h0001);
    @(posedge clk); #1;
    chk("nm_err_pulse_end", 16'(bus_b.misalign_err), 16'h0000);
    chk("nm_no_late_valid", 16'(bus_b.readValid), 16'h0000);
    op(1'b1, 1'b1, 1'b0, 16'h0003, 16'hABCD, rdy, rv, err, rd);
    chk("nm_st_err", 16'(err), 16'h0001);
    load_chk(1'b1, "nm_word1", 1'b0, 16'h0002, 16'h1111);
    load_chk(1'b1, "nm_word2", 1'b0, 16'h0004, 16'h0000);
    load_chk(1'b1, "nm_no_preload", 1'b0, 16'h0000, 16'h0000);

    // Reset in the middle of a misaligned store.
    op(1'b0, 1'b1, 1'b0, 16'h0051, 16'hBEEF, rdy, rv, err, rd);
    chk("midsplit_ready_low", 16'(rdy), 16'h0000);
    reset = 1'b1;
    #1;
    sample(1'b0, rdy, rv, err, rd);
    chk("midsplit_rst_ready", 16'(rdy), 16'h0000);
    chk("midsplit_rst_valid", 16'(rv), 16'h0000);
    chk("midsplit_rst_data", rd, 16'h0000);
    chk("midsplit_rst_err", 16'(err), 16'h0000);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    load_chk(1'b0, "reinit_word0", 1'b0, 16'h0000, 16'h3856);
    load_chk(1'b0, "reinit_lo", 1'b1, 16'h0051, 16'h0000);
    load_chk(1'b0, "reinit_hi", 1'b1, 16'h0052, 16'h0000);
    load_chk(1'b0, "reinit_store_gone", 1'b0, 16'h0010, 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
